// File: rtl/mem_wait_ctrl_pkg.sv
// mem_wait_ctrl_pkg
// Shared constants and types for the memory wait controller:
//   - CNT_W:               width of the external saturating counter (0..5)
//   - DEFAULT_TIMEOUT_CNT: default timeout value, equal to the counter's saturation value
//   - ST_* localparams:    3-bit state encodings (codes 6 and 7 are illegal)
//   - state_t:             enum over the legal states
//   - is_legal_state():    true for codes 0..5
package mem_wait_ctrl_pkg;

    localparam int CNT_W               = 3;
    localparam int DEFAULT_TIMEOUT_CNT = 5;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ISSUE = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_DONE  = 3'd3;
    localparam logic [2:0] ST_TOUT  = 3'd4;
    localparam logic [2:0] ST_ERR   = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE  = ST_IDLE,
        S_ISSUE = ST_ISSUE,
        S_WAIT  = ST_WAIT,
        S_DONE  = ST_DONE,
        S_TOUT  = ST_TOUT,
        S_ERR   = ST_ERR
    } state_t;

    function automatic logic is_legal_state(input logic [2:0] code);
        return (code <= ST_ERR);
    endfunction

endpackage

// File: rtl/mem_wait_ctrl_if.sv
// mem_wait_ctrl_if
// Bundles the controller's request/response and counter-link signals.
//   slave  modport: the controller's view (mem_wait_ctrl)
//   master modport: the surrounding logic's view (pipeline, memory, counter)
//
// Handshake semantics: there is no valid/ready pair. start is a level strobe
// sampled only in IDLE and DONE. mem_req is a one-cycle request pulse; the
// memory answers with mem_ack (plus mem_rdata) which is honoured only while the
// controller is in WAIT and ignored otherwise. done / timeout are one-cycle
// pulses; err is sticky until reset. ctr_rst holds the external counter at 0.
interface mem_wait_ctrl_if #(
    parameter int DATA_W = 16
);
    logic              start;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;
    logic [2:0]        cnt;
    logic              cnt_err;
    logic              ctr_rst;
    logic              mem_req;
    logic              stall;
    logic              done;
    logic              timeout;
    logic [DATA_W-1:0] data_out;
    logic              err;

    modport slave (
        input  start, mem_ack, mem_rdata, cnt, cnt_err,
        output ctr_rst, mem_req, stall, done, timeout, data_out, err
    );

    modport master (
        output start, mem_ack, mem_rdata, cnt, cnt_err,
        input  ctr_rst, mem_req, stall, done, timeout, data_out, err
    );
endinterface

// File: rtl/dff.sv
// dff
// Generic enabled D flip-flop cell with asynchronous active-high reset.
//   clk, rst : clock, async reset (q <= RST_VAL)
//   en       : load enable
//   d, q     : W-bit data in / out
module dff #(
    parameter int           W       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= RST_VAL;
        end else if (en) begin
            q <= d;
        end
    end
endmodule

// File: rtl/mem_wait_ctrl_retry_ctr.sv
// retry_ctr
// 2-bit retry counter for the memory wait controller. Built only when
// MEM_WAIT_RETRY_EN is defined.
//   clk, rst : clock, async reset (count <= 0)
//   clr      : clear to 0 (wins over inc)
//   inc      : increment by one
//   count    : current retry count
`ifdef MEM_WAIT_RETRY_EN
module retry_ctr (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       inc,
    output logic [1:0] count
);
    logic [1:0] count_d;

    assign count_d = clr ? 2'd0 : (count + 2'd1);

    dff #(.W(2), .RST_VAL(2'd0)) u_count (
        .clk (clk),
        .rst (rst),
        .en  (clr | inc),
        .d   (count_d),
        .q   (count)
    );
endmodule
`endif

// File: rtl/mem_wait_ctrl.sv
// mem_wait_ctrl
// Request/timeout controller placed downstream of a saturating 0..5 counter.
// Issues a single-beat memory request, stalls while waiting for mem_ack,
// captures the returned data and declares a timeout when the counter reaches
// TIMEOUT_CNT. Outputs are Moore (decoded from state); data_out is registered.
//
// Optional feature macro: MEM_WAIT_RETRY_EN
//   defined   : a timeout reissues the request up to MAX_RETRY times, then ERR
//   undefined : a timeout returns to IDLE
//
// Ports:
//   clk       : system clock
//   rst       : asynchronous active-high reset
//   bus       : mem_wait_ctrl_if.slave (start, mem_ack, mem_rdata, cnt, cnt_err
//               in; ctr_rst, mem_req, stall, done, timeout, data_out, err out)
//   state_dbg : current 3-bit state code, for observation
module mem_wait_ctrl
    import mem_wait_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CNT = DEFAULT_TIMEOUT_CNT,
    parameter int DATA_W      = 16,
    parameter int MAX_RETRY   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    mem_wait_ctrl_if.slave        bus,
    output logic [2:0]            state_dbg
);
    logic [2:0]        state_raw;
    state_t            state_q;
    state_t            state_d;
    logic [DATA_W-1:0] data_q;
    logic              capture_en;

    logic ctr_rst_o;
    logic mem_req_o;
    logic stall_o;
    logic done_o;
    logic timeout_o;
    logic err_o;

    // State register. The raw code may hold 6/7 after an upset; the decode
    // below steers those to ERR.
    dff #(.W(3), .RST_VAL(ST_IDLE)) u_state (
        .clk (clk),
        .rst (rst),
        .en  (1'b1),
        .d   (state_d),
        .q   (state_raw)
    );

    assign state_q   = state_t'(state_raw);
    assign state_dbg = state_raw;

`ifdef MEM_WAIT_RETRY_EN
    logic [1:0] retries;
    logic       retry_ok;

    assign retry_ok = (retries < 2'(MAX_RETRY));

    retry_ctr u_retry (
        .clk   (clk),
        .rst   (rst),
        .clr   ((state_q == S_IDLE) || (state_q == S_DONE)),
        .inc   ((state_q == S_TOUT) && retry_ok),
        .count (retries)
    );
`endif

    always_comb begin
        state_d   = state_q;
        ctr_rst_o = 1'b1;
        mem_req_o = 1'b0;
        stall_o   = 1'b0;
        done_o    = 1'b0;
        timeout_o = 1'b0;
        err_o     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) state_d = S_ISSUE;
            end
            S_ISSUE: begin
                mem_req_o = 1'b1;
                stall_o   = 1'b1;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                ctr_rst_o = 1'b0;
                stall_o   = 1'b1;
                // Ack beats timeout when both land in the same cycle.
                if (bus.mem_ack) begin
                    state_d = S_DONE;
                end else if (bus.cnt == 3'(TIMEOUT_CNT)) begin
                    state_d = S_TOUT;
                end
            end
            S_DONE: begin
                done_o  = 1'b1;
                state_d = bus.start ? S_ISSUE : S_IDLE;
            end
            S_TOUT: begin
                timeout_o = 1'b1;
`ifdef MEM_WAIT_RETRY_EN
                stall_o   = 1'b1;
                state_d   = retry_ok ? S_ISSUE : S_ERR;
`else
                state_d   = S_IDLE;
`endif
            end
            S_ERR: begin
                err_o = 1'b1;
            end
            default: begin
                // Illegal code: flag immediately, park in ERR.
                err_o   = 1'b1;
                state_d = S_ERR;
            end
        endcase

        // Counter error overrides everything, including a pending ack.
        if (bus.cnt_err) state_d = S_ERR;
    end

    // Capture only on a genuine completion: ack in WAIT without a counter error.
    assign capture_en = (state_q == S_WAIT) && bus.mem_ack && !bus.cnt_err;

    dff #(.W(DATA_W), .RST_VAL('0)) u_data (
        .clk (clk),
        .rst (rst),
        .en  (capture_en),
        .d   (bus.mem_rdata),
        .q   (data_q)
    );

    assign bus.ctr_rst  = ctr_rst_o;
    assign bus.mem_req  = mem_req_o;
    assign bus.stall    = stall_o;
    assign bus.done     = done_o;
    assign bus.timeout  = timeout_o;
    assign bus.err      = err_o;
    assign bus.data_out = data_q;

endmodule

// File: tb/tb_mem_wait_ctrl.sv
// tb_mem_wait_ctrl
// Directed bench for mem_wait_ctrl. Includes a behavioural model of the
// upstream saturating 0..5 counter. done/timeout events are checked by a
// monitor against an expected queue of {cycle, kind, data}.
module tb_mem_wait_ctrl;
    localparam int DW = 16;
    localparam int EW = 32 + 2 + DW;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] state_dbg;
    logic [2:0] cnt_q;
    logic       cnt_err_drv;
    int         cyc;
    int         total = 0;
    int         bad   = 0;
    int         n_req = 0;
    int         n_tout = 0;
    logic [EW-1:0] exp_q[$];

    mem_wait_ctrl_if #(.DATA_W(DW)) bus_if ();

    mem_wait_ctrl #(.TIMEOUT_CNT(5), .DATA_W(DW), .MAX_RETRY(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus_if),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset-related ----------------
    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // Upstream saturating counter model.
    always @(posedge clk or posedge rst) begin
        if (rst)                 cnt_q <= 3'd0;
        else if (bus_if.ctr_rst) cnt_q <= 3'd0;
        else if (cnt_q < 3'd5)   cnt_q <= cnt_q + 3'd1;
    end

    assign bus_if.cnt     = cnt_q;
    assign bus_if.cnt_err = cnt_err_drv;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [EW-1:0] got;
        logic [EW-1:0] want;
        if (!rst) begin
            if (bus_if.mem_req) n_req  = n_req + 1;
            if (bus_if.timeout) n_tout = n_tout + 1;
            if (bus_if.done || bus_if.timeout) begin
                got = {32'(cyc), bus_if.timeout, bus_if.done, bus_if.data_out};
                total = total + 1;
                if (exp_q.size() == 0) begin
                    bad = bad + 1;
                    $display("FAIL unexpected_event cyc=%0d tout=%b done=%b data=%h",
                             cyc, bus_if.timeout, bus_if.done, bus_if.data_out);
                end else begin
                    want = exp_q.pop_front();
                    if (got !== want) begin
                        bad = bad + 1;
                        $display("FAIL event got cyc=%0d kind=%b data=%h want cyc=%0d kind=%b data=%h",
                                 got[EW-1:DW+2], got[DW+1:DW], got[DW-1:0],
                                 want[EW-1:DW+2], want[DW+1:DW], want[DW-1:0]);
                    end
                end
            end
        end
    end

    // ---------------- driver / check tasks ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total = total + 1;
        if (got !== want) begin
            bad = bad + 1;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic push_exp(input int c, input logic [1:0] kind, input logic [DW-1:0] d);
        exp_q.push_back({32'(c), kind, d});
    endtask

    // Wait (bounded) for WAIT state with the counter at v.
    task automatic wait_cnt(input logic [2:0] v);
        int n;
        n = 0;
        while (!(state_dbg == 3'd2 && cnt_q == v) && n < 40) begin
            tick();
            n++;
        end
        if (n >= 40) begin
            total = total + 1;
            bad = bad + 1;
            $display("FAIL wait_cnt got state=%0d cnt=%0d want state=2 cnt=%0d", state_dbg, cnt_q, v);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int c0;
        logic [DW-1:0] last_data;

        rst = 1'b1;
        bus_if.start = 1'b0;
        bus_if.mem_ack = 1'b0;
        bus_if.mem_rdata = '0;
        cnt_err_drv = 1'b0;
        repeat (2) @(posedge clk);
        tick();
        rst = 1'b0;
        tick();

        // Reset state
        check("rst_state",   32'(state_dbg),        32'd0);
        check("rst_ctr_rst", 32'(bus_if.ctr_rst),   32'd1);
        check("rst_mem_req", 32'(bus_if.mem_req),   32'd0);
        check("rst_stall",   32'(bus_if.stall),     32'd0);
        check("rst_err",     32'(bus_if.err),       32'd0);
        check("rst_done",    32'(bus_if.done),      32'd0);
        check("rst_timeout", 32'(bus_if.timeout),   32'd0);
        check("rst_data",    32'(bus_if.data_out),  32'd0);

        // Ack at cnt==2: done 5 cycles after the start cycle
        n_req = 0;
        c0 = cyc;
        bus_if.start = 1'b1;
        push_exp(c0 + 5, 2'b01, 16'hBEEF);
        tick();
        bus_if.start = 1'b0;
        check("issue_mem_req", 32'(bus_if.mem_req), 32'd1);
        check("issue_stall",   32'(bus_if.stall),   32'd1);
        check("issue_state",   32'(state_dbg),      32'd1);
        wait_cnt(3'd2);
        check("ack_cycle",     32'(cyc - c0),       32'd4);
        check("wait_ctr_rst",  32'(bus_if.ctr_rst), 32'd0);
        check("wait_stall",    32'(bus_if.stall),   32'd1);
        bus_if.mem_ack = 1'b1;
        bus_if.mem_rdata = 16'hBEEF;
        tick();
        bus_if.mem_ack = 1'b0;
        check("done_state",    32'(state_dbg),      32'd3);
        check("done_stall",    32'(bus_if.stall),   32'd0);
        tick();
        check("after_done_state", 32'(state_dbg),   32'd0);
        check("ack_data",      32'(bus_if.data_out), 32'h0000BEEF);
        check("ack_req_count", 32'(n_req),          32'd1);
        last_data = 16'hBEEF;

        // No ack: timeout when the counter reaches 5
        n_req = 0;
        n_tout = 0;
        c0 = cyc;
        bus_if.start = 1'b1;
`ifdef MEM_WAIT_RETRY_EN
        push_exp(c0 + 8,  2'b10, 16'hBEEF);
        push_exp(c0 + 16, 2'b10, 16'hBEEF);
        push_exp(c0 + 24, 2'b10, 16'hBEEF);
`else
        push_exp(c0 + 8,  2'b10, 16'hBEEF);
`endif
        tick();
        bus_if.start = 1'b0;
`ifdef MEM_WAIT_RETRY_EN
        while (cyc < c0 + 26) tick();
        check("retry_state",  32'(state_dbg),  32'd5);
        check("retry_err",    32'(bus_if.err), 32'd1);
        check("retry_stall",  32'(bus_if.stall), 32'd0);
        check("retry_reqs",   32'(n_req),      32'd3);
        check("retry_touts",  32'(n_tout),     32'd3);
        repeat (5) tick();
        check("retry_err_sticky", 32'(bus_if.err), 32'd1);
        do_reset();
        check("retry_rst_err",  32'(bus_if.err),      32'd0);
        check("retry_rst_data", 32'(bus_if.data_out), 32'd0);
        last_data = 16'h0000;
`else
        while (cyc < c0 + 9) tick();
        check("tout_state", 32'(state_dbg),  32'd0);
        check("tout_err",   32'(bus_if.err), 32'd0);
        check("tout_reqs",  32'(n_req),      32'd1);
        check("tout_touts", 32'(n_tout),     32'd1);
        check("tout_data",  32'(bus_if.data_out), 32'(last_data));
`endif

        // Ack and cnt==TIMEOUT_CNT together: done wins
        n_tout = 0;
        c0 = cyc;
        bus_if.start = 1'b1;
        push_exp(c0 + 8, 2'b01, 16'h1234);
        tick();
        bus_if.start = 1'b0;
        wait_cnt(3'd5);
        bus_if.mem_ack = 1'b1;
        bus_if.mem_rdata = 16'h1234;
        tick();
        bus_if.mem_ack = 1'b0;
        tick();
        check("race_state", 32'(state_dbg),        32'd0);
        check("race_touts", 32'(n_tout),           32'd0);
        check("race_data",  32'(bus_if.data_out),  32'h00001234);

        // cnt_err together with ack: ERR, no done, no capture
        bus_if.start = 1'b1;
        tick();
        bus_if.start = 1'b0;
        wait_cnt(3'd1);
        bus_if.mem_ack = 1'b1;
        bus_if.mem_rdata = 16'h5555;
        cnt_err_drv = 1'b1;
        tick();
        bus_if.mem_ack = 1'b0;
        cnt_err_drv = 1'b0;
        check("cerr_state", 32'(state_dbg),       32'd5);
        check("cerr_err",   32'(bus_if.err),      32'd1);
        check("cerr_done",  32'(bus_if.done),     32'd0);
        check("cerr_stall", 32'(bus_if.stall),    32'd0);
        check("cerr_data",  32'(bus_if.data_out), 32'h00001234);
        repeat (3) tick();
        check("cerr_sticky", 32'(bus_if.err), 32'd1);
        do_reset();

        // Back-to-back: start held through DONE
        n_req = 0;
        c0 = cyc;
        bus_if.start = 1'b1;
        push_exp(c0 + 3, 2'b01, 16'hAAAA);
        push_exp(c0 + 6, 2'b01, 16'h5A5A);
        tick();
        tick();
        check("b2b_wait0_state", 32'(state_dbg), 32'd2);
        check("b2b_wait0_cnt",   32'(cnt_q),     32'd0);
        bus_if.mem_ack = 1'b1;
        bus_if.mem_rdata = 16'hAAAA;
        tick();
        bus_if.mem_ack = 1'b0;
        check("b2b_done_state", 32'(state_dbg), 32'd3);
        tick();
        check("b2b_reissue_state", 32'(state_dbg),      32'd1);
        check("b2b_reissue_req",   32'(bus_if.mem_req), 32'd1);
        bus_if.start = 1'b0;
        tick();
        bus_if.mem_ack = 1'b1;
        bus_if.mem_rdata = 16'h5A5A;
        tick();
        bus_if.mem_ack = 1'b0;
        tick();
        check("b2b_idle_state", 32'(state_dbg),       32'd0);
        check("b2b_data",       32'(bus_if.data_out), 32'h00005A5A);
        check("b2b_reqs",       32'(n_req),           32'd2);

        // mem_ack in IDLE is ignored
        bus_if.mem_ack = 1'b1;
        bus_if.mem_rdata = 16'hFFFF;
        tick();
        tick();
        bus_if.mem_ack = 1'b0;
        tick();
        check("idle_ack_data",  32'(bus_if.data_out), 32'h00005A5A);
        check("idle_ack_state", 32'(state_dbg),       32'd0);

        // Reset mid-request: outputs drop without a clock edge
        bus_if.start = 1'b1;
        tick();
        bus_if.start = 1'b0;
        tick();
        check("mid_stall_before", 32'(bus_if.stall), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_stall",   32'(bus_if.stall),    32'd0);
        check("mid_rst_mem_req", 32'(bus_if.mem_req),  32'd0);
        check("mid_rst_data",    32'(bus_if.data_out), 32'd0);
        check("mid_rst_state",   32'(state_dbg),       32'd0);
        tick();
        tick();
        rst = 1'b0;
        repeat (4) tick();

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        if (last_data == 16'hFFFF) $display("note: unexpected data tracking");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
